// File: rtl/deser_fifo_if.sv
// Handshake and status bundle for deser_fifo: serial write side, parallel read side
// and the fill/status outputs. The master drives the in* strobes, the slave (the FIFO) the out* side.
interface deser_fifo_if #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
);
  localparam int unsigned CntW = $clog2(WORD_WIDTH);

  logic                  inWriteEnable;
  logic                  inData;
  logic                  inFlush;
  logic                  inReadEnable;
  logic [WORD_WIDTH-1:0] outData;
  logic [ADDR_WIDTH:0]   outWriteCount;
  logic [ADDR_WIDTH:0]   outReadCount;
  logic [ADDR_WIDTH:0]   outLevel;
  logic [CntW-1:0]       outBitCount;
  logic                  outFull;
  logic                  outEmpty;
  logic                  outAlmostFull;
  logic                  outAlmostEmpty;
  logic                  outWriteError;
  logic                  outReadError;
  logic                  outDone;

  modport master (
    output inWriteEnable, inData, inFlush, inReadEnable,
    input  outData, outWriteCount, outReadCount, outLevel, outBitCount,
    input  outFull, outEmpty, outAlmostFull, outAlmostEmpty,
    input  outWriteError, outReadError, outDone
  );

  modport slave (
    input  inWriteEnable, inData, inFlush, inReadEnable,
    output outData, outWriteCount, outReadCount, outLevel, outBitCount,
    output outFull, outEmpty, outAlmostFull, outAlmostEmpty,
    output outWriteError, outReadError, outDone
  );
endinterface

// File: rtl/deser_fifo.sv
// Bit-serial-input FIFO: assembles single-bit writes into WORD_WIDTH-bit words and
// queues them in a 2^ADDR_WIDTH-deep circular buffer with registered parallel reads.
module deser_fifo #(
  parameter int unsigned WORD_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 2,
  parameter bit          MSB_FIRST       = 1'b0,
  parameter int unsigned ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input logic         inClock,
  input logic         inReset,
  deser_fifo_if.slave bus
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(WORD_WIDTH);
  localparam int unsigned PtrW  = ADDR_WIDTH + 1;

  localparam logic [PtrW-1:0] DepthL  = PtrW'(Depth);
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_WIDTH - 1);

  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  logic [WORD_WIDTH-1:0] mem [Depth];

  logic [PtrW-1:0]       level;
  logic [31:0]           level_ext;
  logic                  full;
  logic                  empty;
  logic                  bit_accept;
  logic                  word_last;
  logic                  pop;
  logic                  push;
  logic [CntW-1:0]       bit_pos;
  logic [WORD_WIDTH-1:0] word_asm;

  // Status decode from registered pointers only.
  always_comb begin
    level     = wr_ptr_q - rd_ptr_q;
    level_ext = 32'(level);
    full      = (level == DepthL);
    empty     = (level == '0);
  end

  // Flush wins over a coincident write; the bit is discarded.
  always_comb begin
    bit_accept = bus.inWriteEnable & ~bus.inFlush;
    word_last  = bit_accept & (bit_cnt_q == LastBit);
    pop        = bus.inReadEnable & ~empty;
    // A full buffer still accepts the word when a pop frees a slot in the same cycle.
    push       = word_last & (~full | pop);
    bit_pos    = MSB_FIRST ? (LastBit - bit_cnt_q) : bit_cnt_q;
    word_asm          = shift_q;
    word_asm[bit_pos] = bus.inData;
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (bus.inFlush || word_last) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (bit_accept) begin
      bit_cnt_d = bit_cnt_q + CntW'(1);
      shift_d   = word_asm;
    end

    wr_ptr_d  = wr_ptr_q + PtrW'(push);
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    rd_data_d = pop ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;

    done_d    = push;
    wr_err_d  = word_last & ~push;
    rd_err_d  = bus.inReadEnable & empty;
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge inClock) begin
    if (push) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= word_asm;
    end
  end

  assign bus.outData        = rd_data_q;
  assign bus.outWriteCount  = wr_ptr_q;
  assign bus.outReadCount   = rd_ptr_q;
  assign bus.outLevel       = level;
  assign bus.outBitCount    = bit_cnt_q;
  assign bus.outFull        = full;
  assign bus.outEmpty       = empty;
  assign bus.outAlmostFull  = (level_ext >= ALMOST_FULL_TH);
  assign bus.outAlmostEmpty = (level_ext <= ALMOST_EMPTY_TH);
  assign bus.outWriteError  = wr_err_q;
  assign bus.outReadError   = rd_err_q;
  assign bus.outDone        = done_q;
endmodule

// File: tb/tb_deser_fifo.sv
// Directed bench for deser_fifo: a cycle table for the basic LSB-first flow, then
// hand-written sequences for full/drop, push-with-pop, flush, reset and wrap-around.
module tb_deser_fifo;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  deser_fifo_if #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) a ();
  deser_fifo_if #(.WORD_WIDTH(8), .ADDR_WIDTH(2)) b ();

  deser_fifo #(.WORD_WIDTH(8), .ADDR_WIDTH(2), .MSB_FIRST(1'b0)) u_lsb (
    .inClock (clk),
    .inReset (rst_n),
    .bus     (a.slave)
  );

  deser_fifo #(.WORD_WIDTH(8), .ADDR_WIDTH(2), .MSB_FIRST(1'b1)) u_msb (
    .inClock (clk),
    .inReset (rst_n),
    .bus     (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] in_v;   // {we, d, flush, re}
    logic [2:0] pulse;  // {done, werr, rerr}
    logic [2:0] lvl;
    logic [2:0] bc;
    logic [7:0] dout;
    logic [1:0] fe;     // {full, empty}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] in_v, input logic [2:0] pulse, input logic [2:0] lvl,
                     input logic [2:0] bc, input logic [7:0] dout, input logic [1:0] fe);
    vec_t v;
    v.in_v = in_v; v.pulse = pulse; v.lvl = lvl; v.bc = bc; v.dout = dout; v.fe = fe;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_bit(input logic bit_v);
    a.inWriteEnable = 1'b1;
    a.inData        = bit_v;
    step();
    a.inWriteEnable = 1'b0;
    a.inData        = 1'b0;
  endtask

  // Writes a byte LSB-first back-to-back, then checks the pulses and that they drop next cycle.
  task automatic push_word(input logic [7:0] w, input logic exp_done, input logic exp_werr);
    for (int i = 0; i < 8; i++) write_bit(w[i]);
    chk("push_done", a.outDone, exp_done);
    chk("push_werr", a.outWriteError, exp_werr);
    step();
    chk("pulse_drop", {a.outDone, a.outWriteError}, 2'b00);
  endtask

  task automatic pop_word(input logic [7:0] exp);
    a.inReadEnable = 1'b1;
    step();
    a.inReadEnable = 1'b0;
    chk("pop_data", a.outData, exp);
    chk("pop_rerr", a.outReadError, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wrcnt"}, a.outWriteCount, 0);
    chk({tag, "_rdcnt"}, a.outReadCount, 0);
    chk({tag, "_level"}, a.outLevel, 0);
    chk({tag, "_bitcnt"}, a.outBitCount, 0);
    chk({tag, "_data"}, a.outData, 0);
    chk({tag, "_pulses"}, {a.outDone, a.outWriteError, a.outReadError}, 3'b000);
    chk({tag, "_flags"}, {a.outFull, a.outEmpty, a.outAlmostFull, a.outAlmostEmpty}, 4'b0101);
  endtask

  logic [7:0] msb_bits;
  logic [7:0] w;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    a.inWriteEnable = 1'b0; a.inData = 1'b0; a.inFlush = 1'b0; a.inReadEnable = 1'b0;
    b.inWriteEnable = 1'b0; b.inData = 1'b0; b.inFlush = 1'b0; b.inReadEnable = 1'b0;

    // Word 1 bits 1,0,1,0,1,1,0,1 -> 0xB5; word 2 bits 0,1,1,1,1,1,1,1 -> 0xFE; gaps between.
    add(4'b1100, 3'b000, 0, 1, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 1, 8'h00, 2'b01);
    add(4'b1000, 3'b000, 0, 2, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 2, 8'h00, 2'b01);
    add(4'b1100, 3'b000, 0, 3, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 3, 8'h00, 2'b01);
    add(4'b1000, 3'b000, 0, 4, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 4, 8'h00, 2'b01);
    add(4'b1100, 3'b000, 0, 5, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 5, 8'h00, 2'b01);
    add(4'b1100, 3'b000, 0, 6, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 6, 8'h00, 2'b01);
    add(4'b1000, 3'b000, 0, 7, 8'h00, 2'b01); add(4'b0000, 3'b000, 0, 7, 8'h00, 2'b01);
    add(4'b1100, 3'b100, 1, 0, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 0, 8'h00, 2'b00);
    add(4'b1000, 3'b000, 1, 1, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 1, 8'h00, 2'b00);
    add(4'b1100, 3'b000, 1, 2, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 2, 8'h00, 2'b00);
    add(4'b1100, 3'b000, 1, 3, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 3, 8'h00, 2'b00);
    add(4'b1100, 3'b000, 1, 4, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 4, 8'h00, 2'b00);
    add(4'b1100, 3'b000, 1, 5, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 5, 8'h00, 2'b00);
    add(4'b1100, 3'b000, 1, 6, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 6, 8'h00, 2'b00);
    add(4'b1100, 3'b000, 1, 7, 8'h00, 2'b00); add(4'b0000, 3'b000, 1, 7, 8'h00, 2'b00);
    add(4'b1100, 3'b100, 2, 0, 8'h00, 2'b00); add(4'b0000, 3'b000, 2, 0, 8'h00, 2'b00);
    add(4'b0001, 3'b000, 1, 0, 8'hB5, 2'b00);
    add(4'b0001, 3'b000, 0, 0, 8'hFE, 2'b01);
    add(4'b0001, 3'b001, 0, 0, 8'hFE, 2'b01);  // read while empty: data holds
    add(4'b0000, 3'b000, 0, 0, 8'hFE, 2'b01);

    repeat (3) @(posedge clk);
    #2;
    chk_reset_state("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (vecs[i]) begin
      {a.inWriteEnable, a.inData, a.inFlush, a.inReadEnable} = vecs[i].in_v;
      step();
      chk($sformatf("vec%0d", i),
          {a.outDone, a.outWriteError, a.outReadError, a.outLevel, a.outBitCount, a.outData,
           a.outFull, a.outEmpty},
          {vecs[i].pulse, vecs[i].lvl, vecs[i].bc, vecs[i].dout, vecs[i].fe});
    end
    {a.inWriteEnable, a.inData, a.inFlush, a.inReadEnable} = 4'b0000;
    chk("t1_ptrs", {a.outWriteCount, a.outReadCount}, {3'd2, 3'd2});

    // MSB-first: bits 1,0,1,1,0,1,0,1 -> 0xB5
    msb_bits = 8'b1011_0101;
    for (int i = 7; i >= 0; i--) begin
      b.inWriteEnable = 1'b1;
      b.inData        = msb_bits[i];
      step();
    end
    b.inWriteEnable = 1'b0;
    chk("msb_done", b.outDone, 1'b1);
    chk("msb_level", b.outLevel, 1);
    b.inReadEnable = 1'b1;
    step();
    b.inReadEnable = 1'b0;
    chk("msb_data", b.outData, 8'hB5);

    // Fill to full, then drop a fifth word.
    for (int k = 1; k <= 4; k++) begin
      push_word(8'(k), 1'b1, 1'b0);
      chk($sformatf("fill%0d_level", k), a.outLevel, k);
      chk($sformatf("fill%0d_af", k), a.outAlmostFull, (k >= 3));
      chk($sformatf("fill%0d_ae", k), a.outAlmostEmpty, (k <= 1));
    end
    chk("fill_full", a.outFull, 1'b1);
    push_word(8'h05, 1'b0, 1'b1);
    chk("drop_level", a.outLevel, 4);
    chk("drop_wrcnt", a.outWriteCount, 6);
    for (int k = 1; k <= 4; k++) pop_word(8'(k));
    chk("drain_empty", a.outEmpty, 1'b1);

    // Read while empty.
    a.inReadEnable = 1'b1;
    step();
    a.inReadEnable = 1'b0;
    chk("rd_empty_err", a.outReadError, 1'b1);
    chk("rd_empty_hold", a.outData, 8'h04);
    step();
    chk("rd_err_drop", a.outReadError, 1'b0);

    // Full buffer: final bit completes in the same cycle as a pop.
    for (int k = 0; k < 4; k++) push_word(8'h11 + 8'(k), 1'b1, 1'b0);
    chk("pp_full", a.outFull, 1'b1);
    w = 8'h15;
    for (int i = 0; i < 7; i++) write_bit(w[i]);
    a.inWriteEnable = 1'b1;
    a.inData        = w[7];
    a.inReadEnable  = 1'b1;
    step();
    {a.inWriteEnable, a.inData, a.inReadEnable} = 3'b000;
    chk("pp_pulses", {a.outDone, a.outWriteError, a.outReadError}, 3'b100);
    chk("pp_level", a.outLevel, 4);
    chk("pp_data", a.outData, 8'h11);
    for (int k = 2; k <= 5; k++) pop_word(8'h10 + 8'(k));
    chk("pp_empty", a.outEmpty, 1'b1);

    // Flush a 3-bit partial word.
    for (int i = 0; i < 3; i++) write_bit(1'b1);
    chk("fl_bc", a.outBitCount, 3);
    {a.inWriteEnable, a.inData, a.inFlush} = 3'b111;
    step();
    {a.inWriteEnable, a.inData, a.inFlush} = 3'b000;
    chk("fl_bc0", a.outBitCount, 0);
    push_word(8'hA5, 1'b1, 1'b0);
    pop_word(8'hA5);

    // Reset mid-word with a word stored.
    push_word(8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) write_bit(1'b1);
    chk("rst_pre_bc", a.outBitCount, 5);
    rst_n = 1'b0;
    #2;
    chk_reset_state("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    push_word(8'h3C, 1'b1, 1'b0);
    chk("rst_level", a.outLevel, 1);
    pop_word(8'h3C);

    // Twenty push/pop pairs wrap both pointers past 2^(ADDR_WIDTH+1).
    for (int i = 0; i < 20; i++) begin
      w = 8'(i * 37 + 5);
      push_word(w, 1'b1, 1'b0);
      pop_word(w);
    end
    chk("wrap_ptrs", {a.outWriteCount, a.outReadCount}, {3'd5, 3'd5});
    chk("wrap_empty", a.outEmpty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/deser_fifo.md
# deser_fifo

Parametrised bit-serial-input FIFO for the transmit/receive datapath. It assembles single-bit writes into WORD_WIDTH-bit words, LSB-first or MSB-first, and stores completed words in a 2^ADDR_WIDTH-deep circular buffer. Words are read out in parallel with registered data. It extends the existing serial-in FIFO with configurable word width, bit order, thresholds, a partial-word flush and a bit-level fill counter.

## Interface
Parameters:
- WORD_WIDTH, 8: bits per assembled word (≥2)
- ADDR_WIDTH, 2: buffer depth DEPTH = 2^ADDR_WIDTH words
- MSB_FIRST, 0: 0 = first serial bit lands in bit 0; 1 = first bit lands in bit WORD_WIDTH-1
- ALMOST_FULL_TH, DEPTH-1: outAlmostFull asserted when level ≥ this
- ALMOST_EMPTY_TH, 1: outAlmostEmpty asserted when level ≤ this

Ports:
- inClock  in  1  clock, rising edge
- inReset  in  1  asynchronous, active-low reset
- inWriteEnable  in  1  sample inData this cycle
- inData  in  1  serial data bit
- inFlush  in  1  discard the partially assembled word
- inReadEnable  in  1  pop one word
- outData  out  WORD_WIDTH  last popped word (registered)
- outWriteCount  out  ADDR_WIDTH+1  write pointer (words pushed, mod 2^(ADDR_WIDTH+1))
- outReadCount  out  ADDR_WIDTH+1  read pointer (words popped, mod 2^(ADDR_WIDTH+1))
- outLevel  out  ADDR_WIDTH+1  stored words, 0..DEPTH
- outBitCount  out  clog2(WORD_WIDTH)  bits held in assembler
- outFull, outEmpty, outAlmostFull, outAlmostEmpty  out  1  status flags
- outWriteError  out  1  one-cycle pulse: completed word dropped (full)
- outReadError  out  1  one-cycle pulse: read while empty
- outDone  out  1  one-cycle pulse: word pushed into buffer

## Operation
- Assembler: shift register plus bit counter. On inWriteEnable, inData is placed at position count (LSB-first) or WORD_WIDTH-1-count (MSB-first), and count increments.
- On the WORD_WIDTH-th bit, the completed word (including the current bit) is pushed if the buffer is not full, or if it is full and a pop occurs in the same cycle. The write pointer increments and outDone pulses. The counter returns to 0.
- Full with no simultaneous pop: the word is dropped, outWriteError pulses, the counter returns to 0, and the pointers are unchanged.
- inFlush clears the counter and the shift register. If inFlush and inWriteEnable coincide, the flush wins and the bit is discarded.
- Read: when inReadEnable is high and the buffer is not empty, mem[rdptr] is registered to outData and the read pointer increments.
- Read while empty: outReadError pulses and outData holds. There is no bypass, even when a push completes in the same cycle.
- Pointers are ADDR_WIDTH+1 bits. The address is the low ADDR_WIDTH bits, and the pointers wrap naturally.
- Level = wrptr − rdptr (mod 2^(ADDR_WIDTH+1)).
- Flags: outFull = (level == DEPTH), outEmpty = (level == 0), plus the threshold compares. All flags are decoded from registered pointers.

## Timing
- Reset (inReset low, asynchronous): pointers, level, bit counter, shift register, outData, outDone and both error outputs go to 0; outEmpty = 1; outAlmostEmpty = 1; outFull = 0; outAlmostFull = 0 unless ALMOST_FULL_TH = 0. The buffer memory is not cleared.
- Reset mid-word discards the partial word. Deassertion is synchronised externally; the block adds no synchronising stage.
- Write latency: the edge that samples the final bit updates wrptr, level and flags; outDone is high for the cycle following that edge.
- Read latency: outData is valid in the cycle after the edge that samples inReadEnable.
- Error and outDone pulses last exactly one cycle per event, with no stretching.
- Simultaneous push and pop: level is unchanged, both pointers advance, and no error is raised when full.
- Back-to-back writes on every cycle are supported: one word every WORD_WIDTH cycles. Reads are supported on every cycle.

## Test plan
- Default parameters, LSB-first: write the bits 1,0,1,0,1,1,0,1 then 0,1,1,1,1,1,1,1 with gaps between writes. Required: outDone pulses twice and level = 2. Then read twice. Required: outData = 0xB5, then 0xFE; then outEmpty = 1.
- MSB_FIRST = 1: write the bits 1,0,1,1,0,1,0,1. Required: read returns 0xB5.
- Fill four words (0x01..0x04). Required: outFull = 1 and outAlmostFull is asserted from level 3. Push a fifth word (0x05). Required: outWriteError pulses, level = 4, and reads return 0x01..0x04 only.
- Read while empty. Required: outReadError pulses and outData holds its previous value.
- Full buffer, completing a word in the same cycle as a read. Required: no error, level stays 4, later reads are in order.
- Write 3 bits, assert inFlush, then write 0xA5. Required: read = 0xA5.
- Assert reset after 5 bits. Required: all outputs return to their reset values and the next 8 bits form a clean word.
- Run 20 push/pop pairs. Required: pointer wrap-around is exercised and data order is preserved.
